multicycle_state_seq: RTL and testbench

- Next-state sequencer for the multicycle CPU control unit.
- Holds the 3-bit control state register and advances it each clock from the current opcode and a memory-ready handshake.
- Its `state` output is the input that the control-signal output decoder consumes.
- Also provides halt detection, illegal-opcode flagging, an instruction-retire pulse and performance counters.

---
 rtl/multicycle_state_seq_pkg.sv | 53 +++++
 rtl/multicycle_state_seq_perf_counter.sv | 38 +++
 rtl/multicycle_state_seq.sv | 139 +++++++++++++
 tb/tb_multicycle_state_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_state_seq_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the multicycle CPU control unit: the 3-bit control
// state encodings and the opcode constants. The next-state sequencer and the
// control-signal output decoder both import this package. The encodings
// therefore live in one place only.
// No ports (package).
package cpu_ctrl_pkg;

  // Control state encodings. The output decoder depends on these exact values.
  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_CEXE = 3'b010,
    ST_MEM  = 3'b011,
    ST_CWB  = 3'b100,
    ST_BEXE = 3'b101,
    ST_AEXE = 3'b110,
    ST_AWB  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Instruction class. Each class selects which path the sequencer takes out of ID.
  typedef enum logic [2:0] {
    OPC_ALU,
    OPC_BRANCH,
    OPC_MEM,
    OPC_JUMP,
    OPC_HALT,
    OPC_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_OR: cls = OPC_ALU;
      OP_BEQ:                cls = OPC_BRANCH;
      OP_SW, OP_LW:          cls = OPC_MEM;
      OP_J:                  cls = OPC_JUMP;
      OP_HALT:               cls = OPC_HALT;
      default:               cls = OPC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_state_seq_perf_counter.sv
// perf_counter
// This is a free-running event counter with an enable input. The count wraps
// modulo 2^CNT_W and does not saturate.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset, clears the count
//   en_i     increment enable, sampled on the rising edge
//   count_o  current count
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_state_seq.sv
// multicycle_state_seq
// This is the next-state sequencer for the multicycle CPU control unit. It
// holds the 3-bit control state and advances it on every clock. The next state
// depends on the opcode and on the memory-ready handshake. The block also
// flags halt and illegal opcodes, pulses once per retired instruction, and
// keeps the cycle and retired-instruction counters.
// Ports:
//   clk_i            system clock; all state changes on the rising edge
//   rst_i            asynchronous active-high reset
//   opcode_i         IR opcode; sampled only in ID and MEM
//   mem_ready_i      memory completion; qualifies leaving IF and MEM
//   state_o          current control state (feeds the output decoder)
//   halted_o         sticky halt flag
//   illegal_op_o     sticky unknown-opcode flag
//   instr_done_o     one-cycle pulse aligned with the return to IF on retire
//   cycle_count_o    clocks since reset while not halted
//   retired_count_o  instructions retired since reset
module multicycle_state_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             illegal_op_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retired_count_o
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic   instr_done_q;
  logic   retire_d;

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;

    case (state_q)
      ST_IF: begin
        // A halted core parks in IF until reset and ignores the fetch handshake.
        if (!halted_q && mem_ready_i) begin
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        case (op_class(opcode_i))
          OPC_ALU:    state_d = ST_AEXE;
          OPC_BRANCH: state_d = ST_BEXE;
          OPC_MEM:    state_d = ST_CEXE;
          OPC_JUMP: begin
            state_d  = ST_IF;
            retire_d = 1'b1;
          end
          OPC_HALT: begin
            state_d  = ST_IF;
            halted_d = 1'b1;
            retire_d = 1'b1;
          end
          default: begin
            state_d   = ST_IF;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_AEXE: state_d = ST_AWB;
      ST_AWB: begin
        state_d  = ST_IF;
        retire_d = 1'b1;
      end
      ST_BEXE: begin
        state_d  = ST_IF;
        retire_d = 1'b1;
      end
      ST_CEXE: state_d = ST_MEM;
      ST_MEM: begin
        if (mem_ready_i) begin
          // Only sw and lw can reach MEM. A store retires here, and a load
          // (the only other option) still has its write-back to do.
          if (opcode_i == OP_SW) begin
            state_d  = ST_IF;
            retire_d = 1'b1;
          end else begin
            state_d = ST_CWB;
          end
        end
      end
      ST_CWB: begin
        state_d  = ST_IF;
        retire_d = 1'b1;
      end
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IF;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      instr_done_q <= retire_d;
    end
  end

  // The cycle counter is gated by the registered halt flag. The edge that
  // decodes halt therefore still counts, and counting stops after that edge.
  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (!halted_q),
    .count_o (cycle_count_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (retire_d),
    .count_o (retired_count_o)
  );

  assign state_o      = state_q;
  assign halted_o     = halted_q;
  assign illegal_op_o = illegal_q;
  assign instr_done_o = instr_done_q;

endmodule

// File: tb/tb_multicycle_state_seq.sv
module tb_multicycle_state_seq;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic [2:0]       state;
  logic             halted;
  logic             illegal_op;
  logic             instr_done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retired_count;

  int checks = 0;
  int errors = 0;
  int cyc_exp = 0;
  bit count_en = 1'b0;

  multicycle_state_seq #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .state_o         (state),
    .halted_o        (halted),
    .illegal_op_o    (illegal_op),
    .instr_done_o    (instr_done),
    .cycle_count_o   (cycle_count),
    .retired_count_o (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then check the state 1 time unit later.
  task automatic tick(input string tag, input logic [2:0] exp_st);
    @(posedge clk);
    #1;
    if (count_en) cyc_exp++;
    chk(tag, 32'(state), 32'(exp_st));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},   32'(state), 32'(ST_IF));
    chk({tag, "_halted"},  32'(halted), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    chk({tag, "_done"},    32'(instr_done), 32'd0);
    chk({tag, "_cycles"},  cycle_count, 32'd0);
    chk({tag, "_retired"}, retired_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    opcode = OP_ADD;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    count_en = 1'b1;
    cyc_exp = 0;

    // add: IF,ID,aEXE,aWB,IF. The opcode is corrupted in aEXE, where it must be ignored.
    opcode = OP_ADD;
    mem_ready = 1'b1;
    tick("add_id", ST_ID);
    tick("add_aexe", ST_AEXE);
    opcode = 6'b101010;
    tick("add_awb", ST_AWB);
    mem_ready = 1'b0;
    tick("add_if", ST_IF);
    chk("add_done", 32'(instr_done), 32'd1);
    chk("add_retired", retired_count, 32'd1);
    chk("add_cycles", cycle_count, 32'd4);
    tick("add_idle", ST_IF);
    chk("add_done_clear", 32'(instr_done), 32'd0);
    $display("add retired: retired=%0d cycles=%0d", retired_count, cycle_count);

    // lw: MEM is held for 2 cycles with mem_ready low.
    opcode = OP_LW;
    mem_ready = 1'b1;
    tick("lw_id", ST_ID);
    mem_ready = 1'b0;
    tick("lw_cexe", ST_CEXE);
    tick("lw_mem0", ST_MEM);
    tick("lw_mem1", ST_MEM);
    tick("lw_mem2", ST_MEM);
    chk("lw_done_wait", 32'(instr_done), 32'd0);
    mem_ready = 1'b1;
    tick("lw_cwb", ST_CWB);
    mem_ready = 1'b0;
    tick("lw_if", ST_IF);
    chk("lw_done", 32'(instr_done), 32'd1);
    chk("lw_retired", retired_count, 32'd2);
    $display("lw retired: retired=%0d cycles=%0d", retired_count, cycle_count);

    // sw, then beq, then j, issued back-to-back.
    opcode = OP_SW;
    mem_ready = 1'b1;
    tick("sw_id", ST_ID);
    tick("sw_cexe", ST_CEXE);
    tick("sw_mem", ST_MEM);
    tick("sw_if", ST_IF);
    chk("sw_retired", retired_count, 32'd3);
    $display("sw retired: retired=%0d", retired_count);
    opcode = OP_BEQ;
    tick("beq_id", ST_ID);
    chk("beq_done_id", 32'(instr_done), 32'd0);
    tick("beq_bexe", ST_BEXE);
    tick("beq_if", ST_IF);
    chk("beq_done", 32'(instr_done), 32'd1);
    chk("beq_retired", retired_count, 32'd4);
    $display("beq retired: retired=%0d", retired_count);
    opcode = OP_J;
    tick("j_id", ST_ID);
    tick("j_if", ST_IF);
    chk("j_done", 32'(instr_done), 32'd1);
    chk("j_retired", retired_count, 32'd5);
    chk("j_cycles", cycle_count, cyc_exp);
    $display("j retired: retired=%0d cycles=%0d", retired_count, cycle_count);

    // Illegal opcode: back to IF, flag set, no retire.
    opcode = 6'b101010;
    tick("ill_id", ST_ID);
    mem_ready = 1'b0;
    tick("ill_if", ST_IF);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_done", 32'(instr_done), 32'd0);
    chk("ill_retired", retired_count, 32'd5);
    $display("illegal opcode: illegal_op=%0d retired=%0d", illegal_op, retired_count);

    // halt: the decode edge is counted, and the core then parks in IF.
    opcode = OP_HALT;
    mem_ready = 1'b1;
    tick("halt_id", ST_ID);
    tick("halt_if", ST_IF);
    count_en = 1'b0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_done", 32'(instr_done), 32'd1);
    chk("halt_retired", retired_count, 32'd6);
    chk("halt_cycles", cycle_count, cyc_exp);
    opcode = OP_ADD;
    for (int i = 0; i < 20; i++) begin
      tick("halt_park", ST_IF);
    end
    chk("halt_cycles_frozen", cycle_count, cyc_exp);
    chk("halt_done_clear", 32'(instr_done), 32'd0);
    chk("halt_illegal_sticky", 32'(illegal_op), 32'd1);
    $display("halt: halted=%0d cycles=%0d", halted, cycle_count);

    // Assert reset mid-cycle while halted. Everything must clear with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_halted");
    @(negedge clk);
    rst = 1'b0;
    count_en = 1'b1;
    cyc_exp = 0;

    // Move into MEM, then assert reset mid-cycle.
    opcode = OP_LW;
    mem_ready = 1'b1;
    tick("mem_id", ST_ID);
    mem_ready = 1'b0;
    tick("mem_cexe", ST_CEXE);
    tick("mem_mem", ST_MEM);
    chk("mem_cycles", cycle_count, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mem");
    $display("async reset in MEM: state=%0d cycles=%0d", state, cycle_count);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
